// File: rtl/exm_if.sv
// Handshake and data bundle between decode, the execute stage and the load-store module.
interface exm_if;
  logic        input_valid_i;
  logic        input_ready_o;
  logic [31:0] pc_i;
  logic [31:0] alu_operand1_i;
  logic [31:0] alu_operand2_i;
  logic [2:0]  alu_op_i;
  logic        alu_sub_i;
  logic        shift_left_i;
  logic        shift_arith_i;
  logic [2:0]  branch_cond_i;
  logic [31:0] branch_base_i;
  logic [31:0] branch_offset_i;
  logic        reg_write_i;
  logic [4:0]  reg_addr_i;
  logic        ls_enable_i;
  logic        ls_write_i;
  logic [1:0]  ls_size_i;
  logic [31:0] ls_write_data_i;

  logic        output_valid_o;
  logic        output_ready_i;
  logic [31:0] alu_result_o;
  logic        ls_enable_o;
  logic        ls_write_o;
  logic [3:0]  ls_sel_o;
  logic [31:0] ls_write_data_o;
  logic        reg_write_o;
  logic [4:0]  reg_addr_o;
  logic        branch_o;
  logic [31:0] branch_target_o;

  modport master (
    output input_valid_i, pc_i, alu_operand1_i, alu_operand2_i, alu_op_i, alu_sub_i,
           shift_left_i, shift_arith_i, branch_cond_i, branch_base_i, branch_offset_i,
           reg_write_i, reg_addr_i, ls_enable_i, ls_write_i, ls_size_i, ls_write_data_i,
           output_ready_i,
    input  input_ready_o, output_valid_o, alu_result_o, ls_enable_o, ls_write_o, ls_sel_o,
           ls_write_data_o, reg_write_o, reg_addr_o, branch_o, branch_target_o
  );

  modport slave (
    input  input_valid_i, pc_i, alu_operand1_i, alu_operand2_i, alu_op_i, alu_sub_i,
           shift_left_i, shift_arith_i, branch_cond_i, branch_base_i, branch_offset_i,
           reg_write_i, reg_addr_i, ls_enable_i, ls_write_i, ls_size_i, ls_write_data_i,
           output_ready_i,
    output input_ready_o, output_valid_o, alu_result_o, ls_enable_o, ls_write_o, ls_sel_o,
           ls_write_data_o, reg_write_o, reg_addr_o, branch_o, branch_target_o
  );
endinterface

// File: rtl/exm.sv
// Execute stage: integer ALU, branch resolution and load-store request formatting,
// with one elastic output register that holds until the load-store module accepts.
module exm (
  input  logic  clk_i,
  input  logic  rst_ni,
  exm_if.slave  bus
);

  localparam logic [2:0] OP_ADD   = 3'd0;
  localparam logic [2:0] OP_XOR   = 3'd1;
  localparam logic [2:0] OP_OR    = 3'd2;
  localparam logic [2:0] OP_AND   = 3'd3;
  localparam logic [2:0] OP_SLT   = 3'd4;
  localparam logic [2:0] OP_SLTU  = 3'd5;
  localparam logic [2:0] OP_SHIFT = 3'd6;

  localparam logic [2:0] BR_NONE   = 3'd0;
  localparam logic [2:0] BR_EQ     = 3'd1;
  localparam logic [2:0] BR_NE     = 3'd2;
  localparam logic [2:0] BR_LT     = 3'd3;
  localparam logic [2:0] BR_GE     = 3'd4;
  localparam logic [2:0] BR_LTU    = 3'd5;
  localparam logic [2:0] BR_GEU    = 3'd6;
  localparam logic [2:0] BR_ALWAYS = 3'd7;

  function automatic logic [31:0] alu_fn(
    input logic signed [31:0] a,
    input logic signed [31:0] b,
    input logic [2:0]         op,
    input logic               sub,
    input logic               left,
    input logic               arith
  );
    logic [4:0] amt;
    logic [31:0] res;
    amt = b[4:0];
    res = '0;
    case (op)
      OP_ADD:   res = sub ? (a - b) : (a + b);
      OP_XOR:   res = a ^ b;
      OP_OR:    res = a | b;
      OP_AND:   res = a & b;
      OP_SLT:   res = {31'd0, (a < b)};
      OP_SLTU:  res = {31'd0, ($unsigned(a) < $unsigned(b))};
      OP_SHIFT: begin
        if (left)       res = a << amt;
        else if (arith) res = a >>> amt;
        else            res = $unsigned(a) >> amt;
      end
      default:  res = '0;
    endcase
    return res;
  endfunction

  function automatic logic taken_fn(
    input logic signed [31:0] a,
    input logic signed [31:0] b,
    input logic [2:0]         cond
  );
    logic t;
    case (cond)
      BR_NONE:   t = 1'b0;
      BR_EQ:     t = (a == b);
      BR_NE:     t = (a != b);
      BR_LT:     t = (a < b);
      BR_GE:     t = (a >= b);
      BR_LTU:    t = ($unsigned(a) < $unsigned(b));
      BR_GEU:    t = ($unsigned(a) >= $unsigned(b));
      BR_ALWAYS: t = 1'b1;
      default:   t = 1'b0;
    endcase
    return t;
  endfunction

  // Half accesses ignore addr[0]; misaligned accesses are not handled here.
  function automatic logic [3:0] sel_fn(
    input logic       en,
    input logic [1:0] size,
    input logic [1:0] addr
  );
    logic [3:0] sel;
    if (!en) begin
      sel = 4'b0000;
    end else begin
      case (size)
        2'd0:    sel = 4'b0001 << addr;
        2'd1:    sel = addr[1] ? 4'b1100 : 4'b0011;
        default: sel = 4'b1111;
      endcase
    end
    return sel;
  endfunction

  function automatic logic [31:0] wdata_fn(
    input logic [1:0]  size,
    input logic [31:0] wd
  );
    logic [31:0] d;
    case (size)
      2'd0:    d = {4{wd[7:0]}};
      2'd1:    d = {2{wd[15:0]}};
      default: d = wd;
    endcase
    return d;
  endfunction

  logic signed [31:0] op1;
  logic signed [31:0] op2;
  logic [31:0]        alu_c;
  logic               taken_c;
  logic [31:0]        target_c;
  logic               xfer_in;
  logic               unused_pc;

  assign op1       = bus.alu_operand1_i;
  assign op2       = bus.alu_operand2_i;
  assign alu_c     = alu_fn(op1, op2, bus.alu_op_i, bus.alu_sub_i,
                            bus.shift_left_i, bus.shift_arith_i);
  assign taken_c   = taken_fn(op1, op2, bus.branch_cond_i);
  assign target_c  = (bus.branch_base_i + bus.branch_offset_i) & 32'hFFFF_FFFE;
  assign unused_pc = ^bus.pc_i;

  logic        vld_p0;
  logic [31:0] alu_p0;
  logic        ls_en_p0;
  logic        ls_wr_p0;
  logic [3:0]  ls_sel_p0;
  logic [31:0] ls_wdata_p0;
  logic        reg_wr_p0;
  logic [4:0]  reg_addr_p0;
  logic        branch_p0;
  logic [31:0] target_p0;

  assign bus.input_ready_o = !vld_p0 || bus.output_ready_i;
  assign xfer_in           = bus.input_valid_i && bus.input_ready_o;

  // ---- stage p0: output register, loaded on transfer in, held while stalled ----
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_p0      <= 1'b0;
      alu_p0      <= '0;
      ls_en_p0    <= 1'b0;
      ls_wr_p0    <= 1'b0;
      ls_sel_p0   <= '0;
      ls_wdata_p0 <= '0;
      reg_wr_p0   <= 1'b0;
      reg_addr_p0 <= '0;
      branch_p0   <= 1'b0;
      target_p0   <= '0;
    end else if (xfer_in) begin
      vld_p0      <= 1'b1;
      alu_p0      <= alu_c;
      ls_en_p0    <= bus.ls_enable_i;
      ls_wr_p0    <= bus.ls_enable_i && bus.ls_write_i;
      ls_sel_p0   <= sel_fn(bus.ls_enable_i, bus.ls_size_i, alu_c[1:0]);
      ls_wdata_p0 <= wdata_fn(bus.ls_size_i, bus.ls_write_data_i);
      reg_wr_p0   <= bus.reg_write_i;
      reg_addr_p0 <= bus.reg_addr_i;
      branch_p0   <= taken_c;
      target_p0   <= target_c;
    end else begin
      if (bus.output_ready_i) vld_p0 <= 1'b0;
      // The redirect is a single pulse, never repeated while the output is held.
      branch_p0 <= 1'b0;
    end
  end

  assign bus.output_valid_o  = vld_p0;
  assign bus.alu_result_o    = alu_p0;
  assign bus.ls_enable_o     = ls_en_p0;
  assign bus.ls_write_o      = ls_wr_p0;
  assign bus.ls_sel_o        = ls_sel_p0;
  assign bus.ls_write_data_o = ls_wdata_p0;
  assign bus.reg_write_o     = reg_wr_p0;
  assign bus.reg_addr_o      = reg_addr_p0;
  assign bus.branch_o        = branch_p0;
  assign bus.branch_target_o = target_p0;

endmodule

// File: tb/tb_exm.sv
// Scoreboard bench for the execute stage: random and directed instructions against a
// plain-arithmetic reference model; a negedge monitor compares every presented output.
module tb_exm;

  logic clk;
  logic rst_n;
  exm_if bus();

  exm dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] op1, op2;
    logic [2:0]  op;
    logic        sub, sl, sa;
    logic [2:0]  cond;
    logic [31:0] base, off;
    logic        rw;
    logic [4:0]  ra;
    logic        le, lw;
    logic [1:0]  size;
    logic [31:0] wd;
  } instr_t;

  typedef struct {
    logic [31:0] alu;
    logic        ls_en, ls_wr;
    logic [3:0]  sel;
    logic [31:0] wd;
    logic        rw;
    logic [4:0]  ra;
    logic        taken;
    logic [31:0] tgt;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  bit   first = 1'b1;
  bit   in_flag = 1'b0;
  bit   b2b = 1'b0;
  bit   rdy_rand = 1'b0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endfunction

  // Reference model: plain arithmetic on the instruction fields.
  function automatic exp_t model(instr_t i);
    exp_t e;
    longint unsigned a, b;
    longint signed sa_v, sb_v;
    a = i.op1; b = i.op2;
    sa_v = $signed(i.op1); sb_v = $signed(i.op2);
    case (i.op)
      3'd0: e.alu = i.sub ? 32'((a + 64'h1_0000_0000 - b) % 64'h1_0000_0000)
                          : 32'((a + b) % 64'h1_0000_0000);
      3'd1: e.alu = i.op1 ^ i.op2;
      3'd2: e.alu = i.op1 | i.op2;
      3'd3: e.alu = i.op1 & i.op2;
      3'd4: e.alu = (sa_v < sb_v) ? 32'd1 : 32'd0;
      3'd5: e.alu = (a < b) ? 32'd1 : 32'd0;
      3'd6: begin
        int n;
        n = int'(i.op2 % 32);
        if (i.sl)      e.alu = 32'((a * (64'd1 << n)) % 64'h1_0000_0000);
        else if (i.sa) e.alu = 32'(sa_v / (64'sd1 <<< n) - ((sa_v < 0 && (sa_v % (64'sd1 <<< n)) != 0) ? 1 : 0));
        else           e.alu = 32'(a / (64'd1 << n));
      end
      default: e.alu = 32'd0;
    endcase
    case (i.cond)
      3'd1: e.taken = (a == b);
      3'd2: e.taken = (a != b);
      3'd3: e.taken = (sa_v < sb_v);
      3'd4: e.taken = (sa_v >= sb_v);
      3'd5: e.taken = (a < b);
      3'd6: e.taken = (a >= b);
      3'd7: e.taken = 1'b1;
      default: e.taken = 1'b0;
    endcase
    e.tgt = 32'(((i.base + 64'd0 + i.off) % 64'h1_0000_0000) / 2 * 2);
    e.ls_en = i.le;
    e.ls_wr = i.le && i.lw;
    if (!i.le) e.sel = 4'd0;
    else if (i.size == 2'd0) e.sel = 4'(1 << (e.alu % 4));
    else if (i.size == 2'd1) e.sel = ((e.alu % 4) >= 2) ? 4'b1100 : 4'b0011;
    else e.sel = 4'b1111;
    if (i.size == 2'd0)      e.wd = (i.wd % 256) * 32'h0101_0101;
    else if (i.size == 2'd1) e.wd = (i.wd % 65536) * 32'h0001_0001;
    else                     e.wd = i.wd;
    e.rw = i.rw;
    e.ra = i.ra;
    return e;
  endfunction

  function automatic instr_t rand_instr();
    instr_t i;
    i.op1  = $urandom();
    i.op2  = ($urandom_range(0, 3) == 0) ? i.op1 : $urandom();
    if ($urandom_range(0, 3) == 0) i.op2 = 32'($urandom_range(0, 40));
    i.op   = 3'($urandom_range(0, 6));
    i.sub  = 1'($urandom_range(0, 1));
    i.sl   = 1'($urandom_range(0, 1));
    i.sa   = 1'($urandom_range(0, 1));
    i.cond = 3'($urandom_range(0, 7));
    i.base = $urandom();
    i.off  = $urandom();
    i.rw   = 1'($urandom_range(0, 1));
    i.ra   = 5'($urandom_range(0, 31));
    i.le   = 1'($urandom_range(0, 1));
    i.lw   = 1'($urandom_range(0, 1));
    i.size = 2'($urandom_range(0, 3));
    i.wd   = $urandom();
    return i;
  endfunction

  function automatic instr_t blank();
    instr_t i;
    i = '{default: '0};
    return i;
  endfunction

  task automatic apply(instr_t i);
    bus.pc_i            = $urandom();
    bus.alu_operand1_i  = i.op1;
    bus.alu_operand2_i  = i.op2;
    bus.alu_op_i        = i.op;
    bus.alu_sub_i       = i.sub;
    bus.shift_left_i    = i.sl;
    bus.shift_arith_i   = i.sa;
    bus.branch_cond_i   = i.cond;
    bus.branch_base_i   = i.base;
    bus.branch_offset_i = i.off;
    bus.reg_write_i     = i.rw;
    bus.reg_addr_i      = i.ra;
    bus.ls_enable_i     = i.le;
    bus.ls_write_i      = i.lw;
    bus.ls_size_i       = i.size;
    bus.ls_write_data_i = i.wd;
  endtask

  // Called just after a posedge; returns just after the accepting posedge.
  task automatic send(instr_t i);
    bit acc;
    int n;
    apply(i);
    bus.input_valid_i = 1'b1;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = bus.input_ready_o;
      @(posedge clk);
      n++;
    end
    if (!acc) begin
      check("send_timeout", 32'd0, 32'd1);
    end else begin
      q.push_back(model(i));
      in_flag = 1'b1;
    end
    #1;
  endtask

  task automatic idle();
    bus.input_valid_i = 1'b0;
    apply(rand_instr());
  endtask

  task automatic drain();
    bus.output_ready_i = 1'b1;
    for (int k = 0; k < 200 && q.size() != 0; k++) @(posedge clk);
    check("drain_empty", 32'(q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  always @(posedge clk) begin
    if (rdy_rand) begin
      #1;
      if (rdy_rand) bus.output_ready_i = ($urandom_range(0, 3) != 0);
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (in_flag) begin
        check("latency_valid", bus.output_valid_o, 1'b1);
        in_flag = 1'b0;
      end
      if (b2b) check("b2b_valid", bus.output_valid_o, 1'b1);
      if (bus.output_valid_o) begin
        if (q.size() == 0) begin
          check("unexpected_output", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = q[0];
          check("alu_result", bus.alu_result_o, e.alu);
          check("ls_enable", bus.ls_enable_o, e.ls_en);
          check("ls_write", bus.ls_write_o, e.ls_wr);
          check("ls_sel", bus.ls_sel_o, e.sel);
          if (e.ls_en) check("ls_wdata", bus.ls_write_data_o, e.wd);
          check("reg_write", bus.reg_write_o, e.rw);
          check("reg_addr", bus.reg_addr_o, e.ra);
          check("branch", bus.branch_o, first && e.taken);
          if (bus.branch_o) check("branch_target", bus.branch_target_o, e.tgt);
          if (!bus.output_ready_i) check("stall_ready_low", bus.input_ready_o, 1'b0);
          if (bus.output_ready_i) begin
            void'(q.pop_front());
            first = 1'b1;
          end else begin
            first = 1'b0;
          end
        end
      end else begin
        check("idle_branch", bus.branch_o, 1'b0);
      end
    end
  end

  task automatic check_reset_outputs();
    check("rst_valid", bus.output_valid_o, 1'b0);
    check("rst_branch", bus.branch_o, 1'b0);
    check("rst_alu", bus.alu_result_o, 32'd0);
    check("rst_sel", bus.ls_sel_o, 4'd0);
    check("rst_ls_en", bus.ls_enable_o, 1'b0);
    check("rst_ls_wr", bus.ls_write_o, 1'b0);
    check("rst_wdata", bus.ls_write_data_o, 32'd0);
    check("rst_reg_wr", bus.reg_write_o, 1'b0);
    check("rst_reg_addr", bus.reg_addr_o, 5'd0);
    check("rst_target", bus.branch_target_o, 32'd0);
    check("rst_in_ready", bus.input_ready_o, 1'b1);
  endtask

  initial begin
    instr_t i;
    rst_n = 1'b0;
    bus.input_valid_i  = 1'b0;
    bus.output_ready_i = 1'b0;
    apply(blank());
    repeat (3) @(posedge clk);
    #1 check_reset_outputs();
    rst_n = 1'b1;
    @(posedge clk); #1;
    bus.output_ready_i = 1'b1;

    // ALU sweep
    i = blank(); i.op1 = 5; i.op2 = 7; i.sub = 1'b1;                       send(i);
    i = blank(); i.op1 = 32'hFFFF_FFFF; i.op2 = 1; i.op = 3'd4;            send(i);
    i = blank(); i.op1 = 32'hFFFF_FFFF; i.op2 = 1; i.op = 3'd5;            send(i);
    i = blank(); i.op1 = 32'h8000_0000; i.op2 = 4; i.op = 3'd6; i.sa = 1;  send(i);
    idle();
    drain();

    // Taken branch held for three stalled cycles, then a not-taken one
    bus.output_ready_i = 1'b0;
    i = blank(); i.op1 = 3; i.op2 = 3; i.cond = 3'd1; i.base = 32'h100; i.off = 32'h21;
    send(i);
    idle();
    repeat (3) @(posedge clk);
    #1 bus.output_ready_i = 1'b1;
    i.cond = 3'd2; send(i);
    idle();
    drain();

    // Store lanes and a load
    i = blank(); i.op1 = 32'h1000; i.op2 = 3; i.le = 1; i.lw = 1; i.size = 0; i.wd = 32'hAB;
    send(i);
    i.op2 = 2; i.size = 1; i.wd = 32'h1234; send(i);
    i.lw = 0; i.size = 2; send(i);
    idle();
    drain();

    // Backpressure mid-stream
    fork
      begin
        for (int k = 0; k < 4; k++) send(rand_instr());
        idle();
      end
      begin
        repeat (2) @(posedge clk);
        #1 bus.output_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 bus.output_ready_i = 1'b1;
      end
    join
    drain();

    // Back-to-back streaming
    bus.output_ready_i = 1'b1;
    send(rand_instr());
    b2b = 1'b1;
    for (int k = 0; k < 20; k++) send(rand_instr());
    idle();
    @(negedge clk);
    b2b = 1'b0;
    drain();

    // Random traffic with random backpressure
    rdy_rand = 1'b1;
    for (int k = 0; k < 300; k++) begin
      send(rand_instr());
      if ($urandom_range(0, 3) == 0) begin
        idle();
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    idle();
    rdy_rand = 1'b0;
    #2;
    drain();

    // Reset asserted while an output is stalled
    bus.output_ready_i = 1'b0;
    send(rand_instr());
    idle();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("midstall_rst_valid", bus.output_valid_o, 1'b0);
    check_reset_outputs();
    q.delete();
    first = 1'b1;
    in_flag = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    bus.output_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1 check("post_rst_valid", bus.output_valid_o, 1'b0);

    i = blank(); i.op1 = 32'h1234; i.op2 = 32'h4321; i.op = 3'd1; send(i);
    idle();
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
